// File: rtl/snd_arbiter.sv
// snd_arbiter: round-robin arbiter that hands a single serial command sender
// to one of three requesters, launches the command, and waits for the
// response or a timeout before releasing the sender.
module snd_arbiter #(
  parameter int unsigned TO_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [4:0] req_start0,
  input  logic [4:0] req_start1,
  input  logic [4:0] req_start2,
  input  logic [3:0] req_len0,
  input  logic [3:0] req_len1,
  input  logic [3:0] req_len2,
  input  logic       resp_rcvd,
  output logic       send,
  output logic [4:0] cmd_start,
  output logic [3:0] cmd_len,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic [2:0] err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [1:0]      rr_ptr;
  logic [1:0]      rr_ptr_nx;
  logic [2:0]      gnt_nx;
  logic [2:0]      ack_nx;
  logic [2:0]      err_nx;
  logic [4:0]      cmd_start_nx;
  logic [3:0]      cmd_len_nx;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_nx;
  logic [TO_W-1:0] cnt_inc;
  logic            timeout;
  logic            settle;

  logic            pick_vld;
  logic [1:0]      pick_idx;
  logic [1:0]      base;
  logic [2:0]      cand;
  logic [4:0]      win_start;
  logic [3:0]      win_len;
  logic [1:0]      owner_idx;
  logic [1:0]      owner_nxt;

  assign send    = (state == SEND);
  assign busy    = (state == SEND) || (state == WAIT);
  assign cnt_inc = cnt + TO_W'(1);
  // Counter reaches all-ones on this edge: the response window is exhausted.
  assign timeout = &cnt_inc;
  // A completion pulse is still on the outputs: stay idle for this cycle.
  assign settle  = |{ack, err};

  // Round-robin search starting at rr_ptr, wrapping 2 -> 0.
  always_comb begin
    base     = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cand = {1'b0, base} + 3'(i);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!pick_vld && req[cand[1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[1:0];
      end
    end
  end

  // Command parameters of the search winner.
  always_comb begin
    win_start = req_start0;
    win_len   = req_len0;
    case (pick_idx)
      2'd1: begin
        win_start = req_start1;
        win_len   = req_len1;
      end
      2'd2: begin
        win_start = req_start2;
        win_len   = req_len2;
      end
      default: ;
    endcase
  end

  // Current owner index and the pointer value that follows it.
  always_comb begin
    owner_idx = 2'd0;
    case (gnt)
      3'b010:  owner_idx = 2'd1;
      3'b100:  owner_idx = 2'd2;
      default: owner_idx = 2'd0;
    endcase
    owner_nxt = (owner_idx == 2'd2) ? 2'd0 : owner_idx + 2'd1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    gnt_nx       = gnt;
    ack_nx       = '0;
    err_nx       = '0;
    cmd_start_nx = cmd_start;
    cmd_len_nx   = cmd_len;
    cnt_nx       = cnt;
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (pick_vld && !settle) begin
          state_nx     = SEND;
          gnt_nx       = 3'b001 << pick_idx;
          cmd_start_nx = win_start;
          cmd_len_nx   = win_len;
          cnt_nx       = '0;
        end
      end
      SEND: begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
      WAIT: begin
        cnt_nx = cnt_inc;
        // Response wins over a timeout landing on the same edge.
        if (resp_rcvd) begin
          ack_nx    = gnt;
          rr_ptr_nx = owner_nxt;
          gnt_nx    = '0;
          state_nx  = IDLE;
        end else if (timeout) begin
          err_nx    = gnt;
          rr_ptr_nx = owner_nxt;
          gnt_nx    = '0;
          state_nx  = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      ack       <= '0;
      err       <= '0;
      cmd_start <= '0;
      cmd_len   <= '0;
      cnt       <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nx;
      gnt       <= gnt_nx;
      ack       <= ack_nx;
      err       <= err_nx;
      cmd_start <= cmd_start_nx;
      cmd_len   <= cmd_len_nx;
      cnt       <= cnt_nx;
    end
  end

endmodule

// File: doc/snd_arbiter.md
SND_ARBITER -- requirements
Module: snd_arbiter

Interface
REQ-001 Parameter TO_W, default 17: width of the response-timeout counter. Timeout is 2^TO_W - 1 cycles.
REQ-002 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset is asynchronous and active-high.
REQ-004 Port req, input, 3: per-requester command request, level, held until that requester's ack or err.
REQ-005 Port req_start0/1/2, input, 5 each: command-ROM start address per requester.
REQ-006 Port req_len0/1/2, input, 4 each: command length in bytes per requester.
REQ-007 Port resp_rcvd, input, 1: single-cycle pulse from the serial command sender when the response is complete.
REQ-008 Port send, output, 1: single-cycle launch strobe to the serial command sender.
REQ-009 Port cmd_start, output, 5: registered start address presented to the sender.
REQ-010 Port cmd_len, output, 4: registered length presented to the sender.
REQ-011 Port gnt, output, 3: one-hot owner of the sender; all-zero when idle.
REQ-012 Port ack, output, 3: one-cycle pulse to the owner on response completion.
REQ-013 Port err, output, 3: one-cycle pulse to the owner on response timeout.
REQ-014 Port busy, output, 1: high in SEND and WAIT.

Function
REQ-015 The FSM shall have states IDLE, SEND, WAIT and no others. Illegal encodings shall return to IDLE.
REQ-016 In IDLE with req != 0, the block shall pick one winner round-robin:
  - search order starts at rr_ptr and wraps 2 to 0;
  - on the same edge it latches gnt, cmd_start and cmd_len from the winner and enters SEND.
REQ-017 In IDLE with req == 0, all outputs shall hold, gnt shall be 0, and the state shall remain IDLE.
REQ-018 In SEND, send shall be 1 for exactly that cycle, then the state moves to WAIT. Latency is one cycle from req sampled in IDLE to send high.
REQ-019 cmd_start, cmd_len and gnt shall stay stable from entry to SEND until the return to IDLE.
REQ-020 In WAIT, a TO_W-bit counter cleared on SEND shall increment each cycle.
REQ-021 resp_rcvd in WAIT shall:
  - pulse ack bit of the owner for one cycle;
  - set rr_ptr to (owner index + 1) mod 3;
  - clear gnt;
  - return the state to IDLE.
REQ-022 When the counter reaches all-ones in WAIT with no resp_rcvd, the block shall:
  - pulse err bit of the owner;
  - advance rr_ptr as in REQ-021;
  - clear gnt;
  - return to IDLE.
REQ-023 resp_rcvd and timeout in the same cycle shall produce ack only, never err.
REQ-024 resp_rcvd in IDLE or SEND shall be ignored, with no ack and no state change.
REQ-025 If the owner deasserts req mid-transaction, the transaction shall complete normally and the ack or err pulse shall still be issued.
REQ-026 Changes to any req_start/req_len after grant shall not affect cmd_start/cmd_len.
REQ-027 At most one bit of gnt, ack and err combined shall be high in any cycle. ack and err shall never be high together.
REQ-028 After ack or err the block shall spend at least one cycle in IDLE, so back-to-back grants space send pulses at least 3 cycles apart when the response is immediate.

Reset
REQ-029 While rst is high the block shall hold:
  - state = IDLE, rr_ptr = 0;
  - send, gnt, ack, err, busy = 0;
  - cmd_start = 0, cmd_len = 0, timeout counter = 0.
REQ-030 rst asserted during SEND or WAIT shall abort immediately, with no ack or err pulse. The first grant after release shall use rr_ptr = 0.

Verification
REQ-031 Single request: req=001, start0=5'h10, len0=4 -> next cycle send=1, cmd_start=5'h10, cmd_len=4, gnt=001. resp_rcvd 20 cycles later -> ack=001 for one cycle, gnt=000.
REQ-032 Rotation: req=111 held, responses immediate -> grant order 0,1,2,0. Each send follows the previous ack by 2 cycles.
REQ-033 Timeout (TO_W=4): req=010, no resp_rcvd -> err=010 exactly 15 cycles after the WAIT entry, no ack, rr_ptr=2.
REQ-034 Collision: resp_rcvd coincides with the timeout cycle -> ack pulses, err stays 0. Stray resp_rcvd in IDLE -> no outputs change.
REQ-035 Mid-op reset: rst high in WAIT for 1 cycle -> all outputs 0 asynchronously. With req=110 afterwards, requester 1 is granted first.
REQ-036 Stability: owner changes req_start0 and drops req during WAIT -> cmd_start unchanged, ack still issued on resp_rcvd.
